// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract engine:
// FSM state encoding and the default operand width.
package serial_add_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_RUN  = 2'b01;
  localparam state_t ST_DONE = 2'b10;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// Single-bit full adder cell, reused one bit per cycle by serial_adder_ctrl.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract engine: one full_adder cell walked LSB-first over WIDTH cycles,
// with valid/ready handshakes on both sides and one operation in flight.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_sum;
  logic fa_carry;

  full_adder u_fa (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .cin   (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // Next-state logic: operand load, per-bit shift/accumulate, result capture on the MSB cycle
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = sub ? ~op_b : op_b;
          carry_d = sub;
          cnt_d   = '0;
          res_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        carry_d = fa_carry;
        // Counter saturates at the MSB cycle instead of wrapping
        if (cnt_q == CNT_LAST) begin
          cnt_d    = cnt_q;
          result_d = {fa_sum, res_q[WIDTH-1:1]};
          cout_d   = fa_carry;
          ovf_d    = carry_q ^ fa_carry;
          state_d  = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): directed vectors, handshake
// corner cases and randomized operations against an arithmetic reference model.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic         busy;

  int tests = 0;
  int fails = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] r;
    logic         c;
    logic         o;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands as unsigned and as signed values
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] r, output logic c, output logic o);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ur = s ? (ua - ub) : (ua + ub);
    sr = s ? (sa - sb) : (sa + sb);
    r  = W'(ur);
    c  = s ? (ua >= ub) : (ur > 255);
    o  = (sr > 127) || (sr < -128);
  endfunction

  // Called just after a negedge; returns with out_valid high (lat = cycles since accept) or lat=-1
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic ordy, output int lat);
    int wait_cnt;
    op_a = a; op_b = b; sub = s; in_valid = 1'b1; out_ready = ordy;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 40) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready %0b required 1", in_ready);
      in_valid = 1'b0;
      lat = -1;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      tests++; fails++;
      $display("FAIL done_timeout: out_valid %0b required 1", out_valid);
      lat = -1;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int stall,
                        input logic [W-1:0] er, input logic ec, input logic eo, input string tag);
    int lat;
    start_op(a, b, s, (stall == 0), lat);
    if (lat < 0) return;
    chk({tag, "_latency"}, 32'(lat), 32'd9);
    chk({tag, "_result"}, 32'(result), 32'(er));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "_stall_hold"}, {23'd0, out_valid, result}, {23'd0, 1'b1, er});
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_back_idle"}, {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
  endtask

  initial begin
    vec_t         vecs [7];
    int           lat;
    logic [W-1:0] ra, rb, er;
    logic         rs, ec, eo;
    logic         saw_valid;

    vecs[0] = '{a: 8'h35, b: 8'h4A, s: 1'b0, r: 8'h7F, c: 1'b0, o: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, s: 1'b0, r: 8'h00, c: 1'b1, o: 1'b0};
    vecs[2] = '{a: 8'h7F, b: 8'h01, s: 1'b0, r: 8'h80, c: 1'b0, o: 1'b1};
    vecs[3] = '{a: 8'h10, b: 8'h20, s: 1'b1, r: 8'hF0, c: 1'b0, o: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h01, s: 1'b1, r: 8'h7F, c: 1'b1, o: 1'b1};
    vecs[5] = '{a: 8'h00, b: 8'h00, s: 1'b1, r: 8'h00, c: 1'b1, o: 1'b0};
    vecs[6] = '{a: 8'h80, b: 8'h80, s: 1'b0, r: 8'h00, c: 1'b1, o: 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op_a = '0; op_b = '0; sub = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_hs", {29'd0, in_ready, out_valid, busy}, {29'd0, 3'b100});
    chk("reset_out", {22'd0, result, cout, overflow}, 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, 0, vecs[i].r, vecs[i].c, vecs[i].o, $sformatf("vec%0d", i));
    end

    // Backpressure: result held for 5 stalled cycles, a pulse on in_valid is ignored
    start_op(8'h35, 8'h4A, 1'b0, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        op_a = 8'h01; op_b = 8'h01; sub = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      chk("bp_hold", {22'd0, out_valid, in_ready, result}, {22'd0, 1'b1, 1'b0, 8'h7F});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {22'd0, in_ready, out_valid, result}, {22'd0, 1'b1, 1'b0, 8'h7F});
    run_op(8'h01, 8'h01, 1'b0, 0, 8'h02, 1'b0, 1'b0, "bp_resend");

    // Reset in the middle of a run aborts the operation
    op_a = 8'hAA; op_b = 8'h55; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_idle", {29'd0, in_ready, out_valid, busy}, {29'd0, 3'b100});
    saw_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    chk("abort_no_valid", 32'(saw_valid), 32'd0);
    run_op(8'h0F, 8'hF0, 1'b0, 0, 8'hFF, 1'b0, 1'b0, "after_abort");

    // Randomized operations with random consumer stalls
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      model(ra, rb, rs, er, ec, eo);
      run_op(ra, rb, rs, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
             er, ec, eo, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
